arc4_sched: RTL and testbench

- Top-level sequencer for the ARC4 datapath.
- On one start request it runs the init, ksa and prga engines in order, each through its en/rdy handshake.
- It time-shares the single-port S memory between them: exactly one engine owns the memory address, write-data and write-enable at any time.
- It sits between the task-level top and the s_mem instance; the memory read data (q) fans out to all engines unchanged.

---
 rtl/arc4_pkg.sv | 24 ++
 rtl/arc4_mem_mux.sv | 45 ++++
 rtl/arc4_sched.sv | 145 ++++++++++++++
 tb/tb_arc4_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 scheduler and its S-memory mux.
package arc4_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Each RUN state is immediately followed by the next phase's START state.
    // The FSM steps to the next state with +1, so this ordering is load-bearing.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT_START = 3'd1,
        S_INIT_RUN   = 3'd2,
        S_KSA_START  = 3'd3,
        S_KSA_RUN    = 3'd4,
        S_PRGA_START = 3'd5,
        S_PRGA_RUN   = 3'd6
    } sched_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INIT = 2'd1;
    localparam logic [1:0] OWN_KSA  = 2'd2;
    localparam logic [1:0] OWN_PRGA = 2'd3;

endpackage

// File: rtl/arc4_mem_mux.sv
// S-memory port mux: forwards the owning engine's request, all-zero when unowned.
// Purely combinational; the owner select is registered upstream.
module arc4_mem_mux
    import arc4_pkg::*;
(
    input  logic [1:0]        owner,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren
);

    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (owner)
            OWN_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            OWN_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            OWN_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// Sequences init -> ksa -> prga on one start and time-shares the S memory port.
// Optional watchdog abort when ARC4_SCHED_WDOG_EN is defined.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic              done,
    output logic              err,
    output logic [1:0]        owner,
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren
);

    sched_state_t state;
    logic         busy_seen;
    logic         cur_rdy;

    always_comb begin
        cur_rdy = 1'b0;
        case (state)
            S_INIT_START, S_INIT_RUN: cur_rdy = init_rdy;
            S_KSA_START,  S_KSA_RUN:  cur_rdy = ksa_rdy;
            S_PRGA_START, S_PRGA_RUN: cur_rdy = prga_rdy;
            default:                  cur_rdy = 1'b0;
        endcase
    end

    assign rdy     = (state == S_IDLE);
    assign init_en = (state == S_INIT_START) & init_rdy;
    assign ksa_en  = (state == S_KSA_START)  & ksa_rdy;
    assign prga_en = (state == S_PRGA_START) & prga_rdy;

`ifdef ARC4_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_cnt;
    logic              err_q;
    assign err = err_q;
`else
    // No watchdog: the controller waits on the engines forever.
    assign err = 1'b0 && (WDOG_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner     <= OWN_NONE;
            done      <= 1'b0;
            busy_seen <= 1'b0;
`ifdef ARC4_SCHED_WDOG_EN
            wdog_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_INIT_START;
                        owner <= OWN_INIT;
`ifdef ARC4_SCHED_WDOG_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                S_INIT_START, S_KSA_START, S_PRGA_START: begin
                    if (cur_rdy) begin
                        state     <= sched_state_t'(state + 3'd1);
                        busy_seen <= 1'b0;
`ifdef ARC4_SCHED_WDOG_EN
                        wdog_cnt  <= '0;
`endif
                    end
                end
                S_INIT_RUN, S_KSA_RUN, S_PRGA_RUN: begin
                    // A phase completes only after its engine was seen busy and is ready again.
                    if (busy_seen && cur_rdy) begin
                        if (state == S_PRGA_RUN) begin
                            state <= S_IDLE;
                            owner <= OWN_NONE;
                            done  <= 1'b1;
                        end else begin
                            state <= sched_state_t'(state + 3'd1);
                            owner <= owner + 2'd1;
                        end
                    end else begin
                        if (!cur_rdy) begin
                            busy_seen <= 1'b1;
                        end
`ifdef ARC4_SCHED_WDOG_EN
                        wdog_cnt <= wdog_cnt + 1'b1;
                        if (wdog_cnt == WDOG_LAST) begin
                            state <= S_IDLE;
                            owner <= OWN_NONE;
                            err_q <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    arc4_mem_mux u_mux (
        .owner       (owner),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
    );

endmodule

// File: tb/tb_arc4_sched.sv
// Directed bench for arc4_sched with simple busy-counter engine models.
module tb_arc4_sched;

`ifdef ARC4_SCHED_WDOG_EN
    localparam int TB_WDOG  = 16;
    localparam int NOM_INIT = 8;
    localparam int NOM_KSA  = 8;
    localparam int NOM_PRGA = 8;
`else
    localparam int TB_WDOG  = 4096;
    localparam int NOM_INIT = 256;
    localparam int NOM_KSA  = 768;
    localparam int NOM_PRGA = 40;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy, done, err;
    logic [1:0] owner;
    logic       init_en, ksa_en, prga_en;
    logic       init_rdy, ksa_rdy, prga_rdy;
    logic [7:0] init_addr = 8'h11, init_wrdata = 8'h21;
    logic [7:0] ksa_addr = 8'h22, ksa_wrdata = 8'h32;
    logic [7:0] prga_addr = 8'h33, prga_wrdata = 8'h43;
    logic       init_wren = 1'b1, ksa_wren = 1'b1, prga_wren = 1'b1;
    logic [7:0] s_addr, s_wrdata;
    logic       s_wren;

    int checks = 0;
    int failures = 0;

    int init_len = 8, ksa_len = 8, prga_len = 8;
    int init_cnt = 0, ksa_cnt = 0, prga_cnt = 0;
    logic ksa_hold = 1'b0;

    assign init_rdy = (init_cnt == 0);
    assign ksa_rdy  = (ksa_cnt == 0) && !ksa_hold;
    assign prga_rdy = (prga_cnt == 0);

    always #5 clk = ~clk;

    // Engine models: rdy drops the cycle after en and stays low for len cycles.
    always @(posedge clk) begin
        if (init_en) init_cnt <= init_len; else if (init_cnt != 0) init_cnt <= init_cnt - 1;
        if (ksa_en)  ksa_cnt  <= ksa_len;  else if (ksa_cnt != 0)  ksa_cnt  <= ksa_cnt - 1;
        if (prga_en) prga_cnt <= prga_len; else if (prga_cnt != 0) prga_cnt <= prga_cnt - 1;
    end

    arc4_sched #(.WDOG_CYCLES(TB_WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .done(done), .err(err), .owner(owner),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .init_wrdata(init_wrdata),
        .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata),
        .prga_addr(prga_addr), .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    // Monitor: pulse counts, owner history and port-mux expectations.
    bit         mon_on = 1'b0;
    int         n_init_en, n_ksa_en, n_prga_en, n_done, mux_err;
    logic [1:0] last_owner = 2'd0;
    logic [1:0] owner_log[$];

    always @(negedge clk) begin
        logic [16:0] exp_port;
        if (mon_on) begin
            if (init_en) n_init_en++;
            if (ksa_en)  n_ksa_en++;
            if (prga_en) n_prga_en++;
            if (done)    n_done++;
            if (owner !== last_owner) begin
                owner_log.push_back(owner);
                last_owner = owner;
            end
            case (owner)
                2'd1:    exp_port = {init_addr, init_wrdata, init_wren};
                2'd2:    exp_port = {ksa_addr, ksa_wrdata, ksa_wren};
                2'd3:    exp_port = {prga_addr, prga_wrdata, prga_wren};
                default: exp_port = 17'd0;
            endcase
            if ({s_addr, s_wrdata, s_wren} !== exp_port) mux_err++;
        end
    end

    task automatic clear_mon();
        n_init_en = 0; n_ksa_en = 0; n_prga_en = 0; n_done = 0; mux_err = 0;
        owner_log.delete();
        last_owner = owner;
    endtask

    task automatic start_run();
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
    endtask

    task automatic wait_owner(input logic [1:0] v, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (owner === v) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rdy !== 1'b1)    begin failures++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
        checks++; if (owner !== 2'd0)  begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if ({init_en, ksa_en, prga_en} !== 3'b000) begin failures++; $display("FAIL reset_en got=%b exp=000", {init_en, ksa_en, prga_en}); end
        checks++; if (s_wren !== 1'b0) begin failures++; $display("FAIL reset_s_wren got=%b exp=0", s_wren); end
        checks++; if (s_addr !== 8'h00) begin failures++; $display("FAIL reset_s_addr got=%h exp=00", s_addr); end
        @(posedge clk); #1 rst_n = 1'b1;
        mon_on = 1'b1;
        clear_mon();
    endtask

    task automatic check_full_run(input string tag);
        #1;
        checks++;
        if (owner_log.size() != 4 || owner_log[0] != 2'd1 || owner_log[1] != 2'd2 ||
            owner_log[2] != 2'd3 || owner_log[3] != 2'd0) begin
            failures++; $display("FAIL %s_owner_seq got_len=%0d exp=1,2,3,0", tag, owner_log.size());
        end
        checks++;
        if (n_init_en != 1 || n_ksa_en != 1 || n_prga_en != 1) begin
            failures++; $display("FAIL %s_en_pulses got=%0d/%0d/%0d exp=1/1/1", tag, n_init_en, n_ksa_en, n_prga_en);
        end
        checks++; if (n_done != 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", tag, n_done); end
        checks++; if (mux_err != 0) begin failures++; $display("FAIL %s_mux got=%0d bad cycles exp=0", tag, mux_err); end
    endtask

    task automatic test_nominal();
        bit ok;
        init_len = NOM_INIT; ksa_len = NOM_KSA; prga_len = NOM_PRGA;
        clear_mon();
        start_run();
        @(negedge clk);
        checks++; if (owner !== 2'd1) begin failures++; $display("FAIL nom_latency_owner got=%0d exp=1", owner); end
        checks++; if (init_en !== 1'b1) begin failures++; $display("FAIL nom_latency_init_en got=%b exp=1", init_en); end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL nom_busy_rdy got=%b exp=0", rdy); end
        wait_done(5000, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL nom_done_timeout got=%b exp=1", ok); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL nom_done_pulse got=%b exp=0", done); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL nom_rdy_back got=%b exp=1", rdy); end
        check_full_run("nom");
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL nom_err got=%b exp=0", err); end
    endtask

    task automatic test_masking();
        bit ok;
        init_len = 8; ksa_len = 8; prga_len = 8;
        clear_mon();
        start_run();
        repeat (3) @(negedge clk);
        init_wren = 1'b0; ksa_wren = 1'b1; ksa_addr = 8'hAA;
        #2;
        checks++; if (s_wren !== 1'b0) begin failures++; $display("FAIL mask_wren got=%b exp=0", s_wren); end
        checks++; if (s_addr !== 8'h11) begin failures++; $display("FAIL mask_addr got=%h exp=11", s_addr); end
        init_wren = 1'b1; init_wrdata = 8'h5C;
        #2;
        checks++; if ({s_wren, s_wrdata} !== {1'b1, 8'h5C}) begin failures++; $display("FAIL mask_init_pass got=%b/%h exp=1/5c", s_wren, s_wrdata); end
        wait_done(500, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mask_done_timeout got=%b exp=1", ok); end
        check_full_run("mask");
        ksa_addr = 8'h22; init_wrdata = 8'h21;
    endtask

    task automatic test_stall();
        bit ok;
        bit en_seen = 1'b0;
        bit owner_bad = 1'b0;
        clear_mon();
        ksa_hold = 1'b1;
        start_run();
        wait_owner(2'd2, 500, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_owner_timeout got=%b exp=1", ok); end
        for (int i = 0; i < 10; i++) begin
            if (ksa_en !== 1'b0) en_seen = 1'b1;
            if (owner !== 2'd2) owner_bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (en_seen !== 1'b0) begin failures++; $display("FAIL stall_ksa_en got=1 exp=0"); end
        checks++; if (owner_bad !== 1'b0) begin failures++; $display("FAIL stall_owner got=moved exp=2"); end
        @(posedge clk); #1 ksa_hold = 1'b0;
        @(negedge clk);
        checks++; if (ksa_en !== 1'b1) begin failures++; $display("FAIL stall_release_ksa_en got=%b exp=1", ksa_en); end
        wait_done(500, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_done_timeout got=%b exp=1", ok); end
        check_full_run("stall");
    endtask

    task automatic test_ignored_start();
        bit ok;
        clear_mon();
        start_run();
        wait_owner(2'd2, 500, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ign_owner_timeout got=%b exp=1", ok); end
        @(posedge clk); #1 en = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({rdy, owner} !== {1'b0, 2'd2}) begin failures++; $display("FAIL ign_state got=%b/%0d exp=0/2", rdy, owner); end
        @(posedge clk); #1 en = 1'b0;
        wait_done(500, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ign_done_timeout got=%b exp=1", ok); end
        check_full_run("ign");
    endtask

    task automatic test_reset_midrun();
        bit ok;
        clear_mon();
        start_run();
        wait_owner(2'd3, 500, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_owner_timeout got=%b exp=1", ok); end
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rstmid_owner got=%0d exp=0", owner); end
        checks++; if (s_wren !== 1'b0) begin failures++; $display("FAIL rstmid_s_wren got=%b exp=0", s_wren); end
        checks++; if ({rdy, done} !== 2'b10) begin failures++; $display("FAIL rstmid_rdy_done got=%b exp=10", {rdy, done}); end
        repeat (12) @(negedge clk);
        clear_mon();
        start_run();
        @(negedge clk);
        checks++; if ({owner, init_en} !== {2'd1, 1'b1}) begin failures++; $display("FAIL rstmid_restart got=%0d/%b exp=1/1", owner, init_en); end
        wait_done(500, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_done_timeout got=%b exp=1", ok); end
        check_full_run("rstmid");
    endtask

`ifdef ARC4_SCHED_WDOG_EN
    task automatic test_wdog();
        bit ok;
        int cyc = 0;
        clear_mon();
        ksa_len = 1000;
        start_run();
        wait_owner(2'd2, 500, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wdog_owner_timeout got=%b exp=1", ok); end
        while (rdy !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc != 17) begin failures++; $display("FAIL wdog_cycles got=%0d exp=17", cyc); end
        checks++; if ({err, owner} !== {1'b1, 2'd0}) begin failures++; $display("FAIL wdog_abort got=%b/%0d exp=1/0", err, owner); end
        #1;
        checks++; if (n_done != 0) begin failures++; $display("FAIL wdog_done got=%0d exp=0", n_done); end
        start_run();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wdog_err_clear got=%b exp=0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_masking();
        test_stall();
        test_ignored_start();
        test_reset_midrun();
`ifdef ARC4_SCHED_WDOG_EN
        test_wdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
